// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter in front of one synchronous-read memory
//                port, with round-robin or fixed-priority tie breaking.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_r0_req,
    input  logic              i_r1_req,
    input  logic              i_r0_we,
    input  logic              i_r1_we,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r0_gnt,
    output logic              o_r1_gnt,
    output logic              o_r0_rvalid,
    output logic              o_r1_rvalid,
    output logic [DATA_W-1:0] o_r0_rdata,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_win;
    logic                r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rv0;
    logic                r_rv1;
    logic                r_mem_we;

    logic                w_pick_r1;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // On a tie, round-robin favours whoever was not granted last; r_last resets to 1
    always_comb begin
        w_pick_r1 = 1'b0;
        if (i_r0_req && i_r1_req) begin
            w_pick_r1 = (FIXED_PRIO == 0) && !r_last;
        end else begin
            w_pick_r1 = i_r1_req;
        end
    end

    always_comb begin
        w_sel_we    = w_pick_r1 ? i_r1_we    : i_r0_we;
        w_sel_addr  = w_pick_r1 ? i_r1_addr  : i_r0_addr;
        w_sel_wdata = w_pick_r1 ? i_r1_wdata : i_r0_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_win    <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_r0_req || i_r1_req) begin
                        r_win    <= w_pick_r1;
                        r_last   <= w_pick_r1;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_gnt0   <= !w_pick_r1;
                        r_gnt1   <= w_pick_r1;
                        r_mem_we <= w_sel_we;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_rv0   <= !r_win;
                        r_rv1   <= r_win;
                        r_state <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_r0_gnt           = r_gnt0;
    assign o_r1_gnt           = r_gnt1;
    assign o_r0_rvalid        = r_rv0;
    assign o_r1_rvalid        = r_rv1;
    assign o_r0_rdata         = r_rv0 ? i_mem_data_read : '0;
    assign o_r1_rdata         = r_rv1 ? i_mem_data_read : '0;
    assign o_mem_addr         = r_addr;
    assign o_mem_data_write   = r_wdata;
    assign o_mem_write_enable = r_mem_we;
    assign o_busy             = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, data width of all data buses.
REQ-002 Parameter: ADDR_W, default 8, address width of all address buses.
REQ-003 Parameter: FIXED_PRIO, default 0; 0 = round-robin, 1 = requester 0 always wins ties.
REQ-004 One clock; reset is asynchronous and active-low; ports: i_clk  input  1  clock; i_rstn  input  1  async active-low reset.
REQ-005 i_r0_req, i_r1_req  input  1 each  requester 0 (CPU datapath) / requester 1 (program loader) access request.
REQ-006 i_r0_we, i_r1_we  input  1 each  1 = write, 0 = read.
REQ-007 i_r0_addr, i_r1_addr  input  ADDR_W each  access address.
REQ-008 i_r0_wdata, i_r1_wdata  input  DATA_W each  write data.
REQ-009 o_r0_gnt, o_r1_gnt  output  1 each  one-cycle grant pulse, command accepted.
REQ-010 o_r0_rvalid, o_r1_rvalid  output  1 each  one-cycle read-data-valid pulse.
REQ-011 o_r0_rdata, o_r1_rdata  output  DATA_W each  read data, meaningful only while the matching rvalid = 1.
REQ-012 o_mem_addr  output  ADDR_W;  o_mem_data_write  output  DATA_W;  o_mem_write_enable  output  1  shared memory port.
REQ-013 i_mem_data_read  input  DATA_W  memory read data, valid one cycle after address is presented (synchronous read).
REQ-014 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS, READ_WAIT.
REQ-016 Requests SHALL be sampled only in IDLE; on a rising clock edge in IDLE with any request, the winner's we/addr/wdata SHALL be latched and the state SHALL go to ACCESS.
REQ-017 Only one requester active: it SHALL win regardless of priority mode.
REQ-018 Both active, FIXED_PRIO=0: the requester not granted most recently SHALL win; last-grant pointer SHALL update on every grant.
REQ-019 Both active, FIXED_PRIO=1: requester 0 SHALL win; pointer still updates.
REQ-020 In ACCESS: o_mem_addr/o_mem_data_write SHALL carry the latched command, the winner's o_rX_gnt SHALL be 1 for exactly this cycle, o_mem_write_enable SHALL equal the latched we.
REQ-021 ACCESS with write SHALL go to IDLE; ACCESS with read SHALL go to READ_WAIT.
REQ-022 In READ_WAIT: winner's o_rX_rvalid = 1 and o_rX_rdata = i_mem_data_read (combinational pass-through); o_mem_write_enable = 0; next state IDLE.
REQ-023 Latency: req seen at edge T -> gnt during cycle T+1 -> read data/rvalid during cycle T+2; back-to-back throughput one write per 2 cycles, one read per 3 cycles.
REQ-024 Requester SHALL hold req and command stable until gnt and deassert req the cycle after gnt; a req still high on return to IDLE SHALL be treated as a new transaction.
REQ-025 Non-winner's gnt/rvalid SHALL stay 0; a losing request SHALL remain pending and be served on the next IDLE.
REQ-026 o_mem_write_enable SHALL be 0 in IDLE and READ_WAIT; o_mem_addr/o_mem_data_write SHALL hold the last latched values outside ACCESS.
REQ-027 At most one gnt and at most one rvalid SHALL be high in any cycle; gnt and rvalid SHALL never be high in the same cycle.
REQ-028 Address and data SHALL pass through unmodified; no wrap or width conversion.

Reset
REQ-029 i_rstn low SHALL immediately force: state IDLE, all gnt/rvalid 0, o_mem_write_enable 0, o_mem_addr 0, o_mem_data_write 0, latched command 0, o_busy 0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-030 Reset asserted during ACCESS SHALL abort the write (write-enable drops asynchronously); reset during READ_WAIT SHALL suppress rvalid; no pending request SHALL be remembered.
REQ-031 After reset release, the first edge with i_rstn high SHALL sample requests normally.

Verification
REQ-032 r0 write addr 0x10 data 0xA5, r1 idle -> o_r0_gnt and o_mem_write_enable high in cycle T+1 with addr 0x10/data 0xA5; idle at T+2.
REQ-033 After REQ-032, r1 read addr 0x10 -> o_r1_gnt at T+1, o_r1_rvalid at T+2 with o_r1_rdata 0xA5, o_r0_rvalid stays 0.
REQ-034 Both request continuously, FIXED_PRIO=0, reads -> grants alternate r0, r1, r0, r1 starting with r0 after reset.
REQ-035 Same stimulus, FIXED_PRIO=1 -> every grant goes to r0; r1 never granted while r0 holds req.
REQ-036 Assert i_rstn low mid-ACCESS of a write to 0x20 data 0x3C -> write-enable drops same cycle, memory at 0x20 unchanged, all outputs at reset values.
REQ-037 Random concurrent traffic, 10k cycles -> scoreboard: every read returns last data written to that address, never two gnt/rvalid in one cycle.
